// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and state encoding for the CNN pooling blocks.
//   DATA_W_DEF   - default signed element width
//   OUT_COLS_DEF - default pooled outputs per row
//   OUT_ROWS_DEF - default pooled rows per frame
//   pool_state_t - frame sequencer state encoding
package cnn_pkg;

  localparam int DATA_W_DEF   = 22;
  localparam int OUT_COLS_DEF = 14;
  localparam int OUT_ROWS_DEF = 14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_t;

endpackage

// File: rtl/max2_signed.sv
// max2_signed: registered two's-complement maximum of two operands.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   en        : operands valid this cycle; when low the outputs load 0
//   a, b      : signed operands, a is the lower-index element
//   max_q     : registered max(a, b)
//   sel_q     : registered select bit, 1 when b won
// Ties go to a: b only wins when strictly greater.
module max2_signed
  import cnn_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max_q,
  output logic         sel_q
);

  logic b_wins;

  assign b_wins = $signed(b) > $signed(a);

  // Clearing on !en keeps the downstream data at 0 between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_q <= '0;
      sel_q <= 1'b0;
    end else if (en) begin
      max_q <= b_wins ? b : a;
      sel_q <= b_wins;
    end else begin
      max_q <= '0;
      sel_q <= 1'b0;
    end
  end

endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: two-stage 2x2 signed max pooling with output position tracking.
// Optional feature macro: POOL_ARGMAX_EN adds output pool_argmax.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   win_valid    : one strobe per 2x2 window
//   x_m_1        : left column  {e0 (upper), e1 (lower)}
//   x_m_2        : right column {e2 (upper), e3 (lower)}
//   pool_valid   : pooled result strobe, 2 cycles after win_valid
//   pool_data    : signed window maximum, 0 when pool_valid low
//   pool_col/row : output position of pool_data, 0 when pool_valid low
//   pool_argmax  : winning element index 0..3 (POOL_ARGMAX_EN only)
//   frame_done   : pulses with the last output of a frame
//   busy         : frame in progress or pipeline holding data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame open, waiting for the first window
// RUN     | frame open; leaves after frame_done unless a new window is in
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OUT_COLS = OUT_COLS_DEF,
  parameter int OUT_ROWS = OUT_ROWS_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        win_valid,
  input  logic [2*DATA_W-1:0]         x_m_1,
  input  logic [2*DATA_W-1:0]         x_m_2,
  output logic                        pool_valid,
  output logic [DATA_W-1:0]           pool_data,
  output logic [$clog2(OUT_COLS)-1:0] pool_col,
  output logic [$clog2(OUT_ROWS)-1:0] pool_row,
`ifdef POOL_ARGMAX_EN
  output logic [1:0]                  pool_argmax,
`endif
  output logic                        frame_done,
  output logic                        busy
);

  localparam int COL_W = $clog2(OUT_COLS);
  localparam int ROW_W = $clog2(OUT_ROWS);

  pool_state_t       state;
  logic              v1, v2;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [DATA_W-1:0] m01, m23, pool_max;
  logic              s01, s23, pool_sel;
  logic              col_last, row_last;

  max2_signed #(.W(DATA_W)) u_max01 (
    .clk   (clk),
    .rstn  (rstn),
    .en    (win_valid),
    .a     (x_m_1[2*DATA_W-1:DATA_W]),
    .b     (x_m_1[DATA_W-1:0]),
    .max_q (m01),
    .sel_q (s01)
  );

  max2_signed #(.W(DATA_W)) u_max23 (
    .clk   (clk),
    .rstn  (rstn),
    .en    (win_valid),
    .a     (x_m_2[2*DATA_W-1:DATA_W]),
    .b     (x_m_2[DATA_W-1:0]),
    .max_q (m23),
    .sel_q (s23)
  );

  max2_signed #(.W(DATA_W)) u_max_out (
    .clk   (clk),
    .rstn  (rstn),
    .en    (v1),
    .a     (m01),
    .b     (m23),
    .max_q (pool_max),
    .sel_q (pool_sel)
  );

  assign col_last   = col_cnt == COL_W'(OUT_COLS - 1);
  assign row_last   = row_cnt == ROW_W'(OUT_ROWS - 1);
  assign frame_done = v2 && col_last && row_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      v1      <= 1'b0;
      v2      <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      v1 <= win_valid;
      v2 <= v1;
      if (v2) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
        end else begin
          col_cnt <= col_cnt + COL_W'(1);
        end
      end
      case (state)
        ST_IDLE: if (win_valid) state <= ST_RUN;
        // A window already in stage 1 belongs to the next frame, so stay open.
        ST_RUN:  if (frame_done && !win_valid && !v1) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pool_valid = v2;
  assign pool_data  = pool_max;
  assign pool_col   = v2 ? col_cnt : '0;
  assign pool_row   = v2 ? row_cnt : '0;
  assign busy       = (state == ST_RUN) || v1 || v2;

`ifdef POOL_ARGMAX_EN
  logic s01_d, s23_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s01_d <= 1'b0;
      s23_d <= 1'b0;
    end else if (v1) begin
      s01_d <= s01;
      s23_d <= s23;
    end else begin
      s01_d <= 1'b0;
      s23_d <= 1'b0;
    end
  end

  // All three select flops are 0 when no result is valid, giving index 0.
  assign pool_argmax = pool_sel ? {1'b1, s23_d} : {1'b0, s01_d};
`else
  // Select bits have no consumer in this build and are trimmed in synthesis.
  logic unused_sel;
  assign unused_sel = s01 ^ s23 ^ pool_sel;
`endif

endmodule
